sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Arbitrates two SDRAM clients plus an internal refresh source onto the single command port of the 16-bit SDRAM memory controller. Clients are the video fetch engine (read-only, latency-critical) and the CPU/host port (read/write). The block sits between the VDP core and the memory controller. It issues one command at a time, tracks the controller's `busy` handshake, and routes read data back to the requester.

## Interface
- `REFRESH_CYCLES`, 421 — clocks between refresh requests (7.8 µs at 54 MHz)
- `CPU_MAX_WAIT`, 4 — consecutive video grants allowed while the CPU request is pending
- `BUSY_TIMEOUT`, 2 — cycles after issue within which `mc_busy` must rise
- `clk` in 1 — main logic clock
- `resetn` in 1 — asynchronous, active-low reset
- `vid_req` in 1 — video read request; held until `vid_ack`
- `vid_addr` in 22 — video word address
- `vid_ack` out 1 — one-cycle pulse when the video command is issued
- `vid_rdata` out 16 — video read data
- `vid_rvalid` out 1 — one-cycle pulse when `vid_rdata` is valid
- `cpu_req` in 1 — CPU request; held with fields stable until `cpu_ack`
- `cpu_we` in 1 — 1 = write, 0 = read
- `cpu_addr` in 22 — CPU word address
- `cpu_wdata` in 16 — CPU write data
- `cpu_wdm` in 2 — write byte mask, passed through to the controller
- `cpu_ack` out 1 — one-cycle pulse when the CPU command is issued
- `cpu_rdata` out 16 — CPU read data
- `cpu_rvalid` out 1 — one-cycle pulse when `cpu_rdata` is valid
- `mc_read` out 1 — controller read strobe
- `mc_write` out 1 — controller write strobe
- `mc_refresh` out 1 — controller refresh strobe
- `mc_addr` out 22 — controller address
- `mc_din` out 16 — controller write data
- `mc_wdm` out 2 — controller write byte mask
- `mc_dout` in 16 — controller read data; holds the last read value after `busy` falls
- `mc_busy` in 1 — controller busy; high through init and for 4 cycles per command
- `err` out 1 — sticky; set on `mc_busy` timeout

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - Leaves only when `mc_busy`=0 and at least one source is pending.
  - Latches the winner, registers the command, and moves to ISSUE.
- **Winner priority**, highest first:
  1. Urgent refresh (pending count ≥ 2).
  2. Starved CPU (starve counter = `CPU_MAX_WAIT`).
  3. Video.
  4. CPU.
  5. Non-urgent refresh (pending count = 1).
- **ISSUE**
  - Exactly one of `mc_read`/`mc_write`/`mc_refresh` is high.
  - `mc_addr`/`mc_din`/`mc_wdm` are valid. For video: `mc_din`=0, `mc_wdm`=0.
  - The winner's ack pulses; a refresh grant decrements the pending count.
  - Next state: WAIT_BUSY.
- **WAIT_BUSY**
  - On `mc_busy`=1, go to WAIT_DONE.
  - If `mc_busy` stays 0 for `BUSY_TIMEOUT` cycles: set `err`, return to IDLE, emit no rvalid.
- **WAIT_DONE**
  - On `mc_busy`=0, return to IDLE.
  - If the op was a read, register `mc_dout` into the owner's rdata and pulse its rvalid next cycle.
  - Writes and refreshes produce no rvalid.
- **Starve counter**
  - Increments on each video grant while `cpu_req`=1, saturating at `CPU_MAX_WAIT`.
  - Clears on a CPU grant or when `cpu_req`=0.
- **Refresh timer**
  - Counts down from `REFRESH_CYCLES`-1; at 0 it reloads.
  - At 0 the 2-bit pending count increments, saturating at 3.
  - If a refresh is granted in the same cycle the timer expires, the count is unchanged.
- **Commands in flight**: `mc_*` strobes stay low outside ISSUE; there is never more than one command in flight.
- **Request withdrawal**: a client dropping `req` before ack is tolerated; no ack is generated for it.
- **Reset values**: all outputs 0, FSM = IDLE, pending = 0, starve = 0, timer = `REFRESH_CYCLES`-1.
- **Reset mid-operation**: the current operation is abandoned silently. After reset the block waits in IDLE until the controller's init completes (`mc_busy`=0).

## Timing
- Request seen in IDLE at cycle 0:
  - ack and strobe at cycle 1;
  - `mc_busy` high cycles 2–5;
  - busy=0 seen in WAIT_DONE at cycle 6;
  - rvalid/rdata at cycle 7.
- Back-to-back command period: 7 cycles (next ISSUE at cycle 8).
- Arbitration is decided on the IDLE cycle only; requests arriving during an operation wait.

## Configuration
- `SDRAM_ARB_REFRESH_EN` defined:
  - the refresh timer and pending logic are compiled in;
  - refresh arbitration is as described above.
- `SDRAM_ARB_REFRESH_EN` undefined:
  - there is no timer, and `mc_refresh` is tied 0;
  - arbitration is starved CPU > video > CPU.
  - Intended for short simulations and external-refresh builds.

## Structure
- Package `sdram_arb_pkg`:
  - `arb_state_t` (4 states);
  - `arb_src_t` (SRC_VID, SRC_CPU, SRC_REF);
  - `ADDR_W`=22, `DATA_W`=16, `WDM_W`=2.
- Sub-module `sdram_refresh_timer`:
  - countdown timer plus saturating pending count;
  - inputs `grant`; outputs `pending`, `urgent`;
  - instantiated only under `SDRAM_ARB_REFRESH_EN`.

## Test plan
- **Single video read**: controller model returns 0xBEEF.
  - `vid_req`, addr 0x12345 at cycle 0 → `mc_read`=1 with `mc_addr`=0x12345 at cycle 1.
  - `vid_rvalid` with `vid_rdata`=0xBEEF at cycle 7.
- **CPU write**: `cpu_we`=1, data 0xA55A, `cpu_wdm`=2'b01 → single `mc_write` carrying 0xA55A and mask 01; `cpu_ack` once; no `cpu_rvalid`.
- **Starvation**: `vid_req` and `cpu_req` held continuously → 4 video grants, then 1 CPU grant, then the pattern repeats.
- **Refresh urgency**: idle for 2×`REFRESH_CYCLES` with `vid_req` then asserted.
  - The next grant is `mc_refresh`, then video, then a second refresh only once the ports are idle.
- **Busy timeout**: controller model never raises busy → `err`=1 at ISSUE+3; FSM back in IDLE; `err` stays 1 until reset.
- **Reset mid-read**: `resetn` low during WAIT_DONE → all outputs 0 immediately; no rvalid; the next request is issued only after the model drops `mc_busy`.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM command-port arbiter.
package sdram_arb_pkg;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;
  localparam int WDM_W  = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} arb_state_t;
  typedef enum logic [1:0] {SRC_VID, SRC_CPU, SRC_REF} arb_src_t;
endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval countdown feeding a 2-bit saturating count of owed refreshes.
module sdram_refresh_timer #(
  parameter int REFRESH_CYCLES = 421
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       grant,
  output logic [1:0] pending,
  output logic       urgent
);
  localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

  logic [CW-1:0] timer;
  logic          expire;

  assign expire = (timer == '0);
  assign urgent = pending[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer   <= CW'(REFRESH_CYCLES - 1);
      pending <= 2'd0;
    end else begin
      timer <= expire ? CW'(REFRESH_CYCLES - 1) : timer - 1'b1;
      // A grant landing on the expiry cycle cancels the increment.
      if (expire && !grant) begin
        if (pending != 2'd3) pending <= pending + 2'd1;
      end else if (grant && !expire && pending != 2'd0) begin
        pending <= pending - 2'd1;
      end
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Video/CPU/refresh arbiter for the single SDRAM controller command port.
// Refresh timer and refresh arbitration are built only with SDRAM_ARB_REFRESH_EN.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int REFRESH_CYCLES = 421,
  parameter int CPU_MAX_WAIT   = 4,
  parameter int BUSY_TIMEOUT   = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [WDM_W-1:0]  cpu_wdm,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              mc_read,
  output logic              mc_write,
  output logic              mc_refresh,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_din,
  output logic [WDM_W-1:0]  mc_wdm,
  input  logic [DATA_W-1:0] mc_dout,
  input  logic              mc_busy,
  output logic              err
);
  localparam int SW = $clog2(CPU_MAX_WAIT + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t    state, state_nxt;
  arb_src_t      src, win;
  logic          go, rd_op, timeout;
  logic [SW-1:0] starve;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    ref_pending;
  logic          ref_urgent;

`ifdef SDRAM_ARB_REFRESH_EN
  logic ref_grant;
  assign ref_grant = (state == ISSUE) && (src == SRC_REF);

  sdram_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_refresh (
    .clk     (clk),
    .resetn  (resetn),
    .grant   (ref_grant),
    .pending (ref_pending),
    .urgent  (ref_urgent)
  );
`else
  logic unused_refresh_cfg;
  assign ref_pending        = 2'd0;
  assign ref_urgent         = 1'b0;
  assign mc_refresh         = 1'b0;
  assign unused_refresh_cfg = ^32'(REFRESH_CYCLES);
`endif

  assign timeout = (state == WAIT_BUSY) && !mc_busy && (tmo_cnt == TW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    win       = SRC_VID;
    case (state)
      IDLE: if (!mc_busy) begin
        go = 1'b1;
        if (ref_urgent)                                  win = SRC_REF;
        else if (cpu_req && starve == SW'(CPU_MAX_WAIT)) win = SRC_CPU;
        else if (vid_req)                                win = SRC_VID;
        else if (cpu_req)                                win = SRC_CPU;
        else if (ref_pending != 2'd0)                    win = SRC_REF;
        else                                             go  = 1'b0;
        if (go) state_nxt = ISSUE;
      end
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (mc_busy) state_nxt = WAIT_DONE;
                 else if (timeout) state_nxt = IDLE;
      WAIT_DONE: if (!mc_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src        <= SRC_VID;
      rd_op      <= 1'b0;
      starve     <= '0;
      tmo_cnt    <= '0;
      err        <= 1'b0;
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_rdata  <= '0;
      cpu_rdata  <= '0;
      vid_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      mc_read    <= 1'b0;
      mc_write   <= 1'b0;
      mc_addr    <= '0;
      mc_din     <= '0;
      mc_wdm     <= '0;
`ifdef SDRAM_ARB_REFRESH_EN
      mc_refresh <= 1'b0;
`endif
    end else begin
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      mc_read    <= 1'b0;
      mc_write   <= 1'b0;
`ifdef SDRAM_ARB_REFRESH_EN
      mc_refresh <= 1'b0;
`endif
      tmo_cnt <= (state == WAIT_BUSY) ? tmo_cnt + 1'b1 : '0;
      if (timeout) err <= 1'b1;

      // Command is registered on the IDLE decision so strobes/ack land in ISSUE.
      if (go) begin
        src <= win;
        case (win)
          SRC_VID: begin
            vid_ack <= 1'b1;
            mc_read <= 1'b1;
            mc_addr <= vid_addr;
            mc_din  <= '0;
            mc_wdm  <= '0;
            rd_op   <= 1'b1;
          end
          SRC_CPU: begin
            cpu_ack  <= 1'b1;
            mc_read  <= !cpu_we;
            mc_write <= cpu_we;
            mc_addr  <= cpu_addr;
            mc_din   <= cpu_wdata;
            mc_wdm   <= cpu_wdm;
            rd_op    <= !cpu_we;
          end
          default: begin
`ifdef SDRAM_ARB_REFRESH_EN
            mc_refresh <= 1'b1;
`endif
            mc_addr <= '0;
            mc_din  <= '0;
            mc_wdm  <= '0;
            rd_op   <= 1'b0;
          end
        endcase
      end

      if (!cpu_req || (go && win == SRC_CPU))
        starve <= '0;
      else if (go && win == SRC_VID && starve != SW'(CPU_MAX_WAIT))
        starve <= starve + 1'b1;

      if (state == WAIT_DONE && !mc_busy && rd_op) begin
        if (src == SRC_VID) begin
          vid_rdata  <= mc_dout;
          vid_rvalid <= 1'b1;
        end else begin
          cpu_rdata  <= mc_dout;
          cpu_rvalid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed stimulus pushes expected events, a monitor pops them.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_rvalid;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [WDM_W-1:0]  cpu_wdm = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              mc_read, mc_write, mc_refresh;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_din;
  logic [WDM_W-1:0]  mc_wdm;
  logic [DATA_W-1:0] mc_dout = '0;
  logic              mc_busy;
  logic              err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_arbiter dut (
    .clk(clk), .resetn(resetn),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wdm(cpu_wdm), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mc_read(mc_read), .mc_write(mc_write), .mc_refresh(mc_refresh),
    .mc_addr(mc_addr), .mc_din(mc_din), .mc_wdm(mc_wdm),
    .mc_dout(mc_dout), .mc_busy(mc_busy), .err(err)
  );

  // Controller model: busy for 4 cycles after a strobe; init_busy and model_dead for special cases.
  logic [2:0]        bcnt = '0;
  logic              init_busy = 1'b0;
  logic              model_dead = 1'b0;
  logic [DATA_W-1:0] model_rdata = '0;

  always @(posedge clk) begin
    if (!model_dead && (mc_read || mc_write || mc_refresh)) bcnt <= 3'd4;
    else if (bcnt != 3'd0) bcnt <= bcnt - 3'd1;
    if (mc_read) mc_dout <= model_rdata;
  end
  assign mc_busy = init_busy || (bcnt != 3'd0);

  // flags: {cpu_rvalid, vid_rvalid, mc_refresh, mc_write, mc_read, cpu_ack, vid_ack}
  localparam logic [6:0] F_VRD = 7'b0000101;
  localparam logic [6:0] F_CRD = 7'b0000110;
  localparam logic [6:0] F_CWR = 7'b0001010;
  localparam logic [6:0] F_REF = 7'b0010000;
  localparam logic [6:0] F_VRV = 7'b0100000;
  localparam logic [6:0] F_CRV = 7'b1000000;

  typedef struct {
    int                cyc;
    logic [6:0]        flags;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [WDM_W-1:0]  wdm;
  } ev_t;
  ev_t expq[$];

  task automatic push(input int c, input logic [6:0] f, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [WDM_W-1:0] w);
    ev_t e;
    e.cyc = c; e.flags = f; e.addr = a; e.data = d; e.wdm = w;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    logic [6:0] f;
    ev_t        e;
    logic       bad;
    f = {cpu_rvalid, vid_rvalid, mc_refresh, mc_write, mc_read, cpu_ack, vid_ack};
    if (f != 7'd0) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cyc=%0d flags=%b addr=%h din=%h, required no event", cyc, f, mc_addr, mc_din);
      end else begin
        e = expq.pop_front();
        bad = (f != e.flags) || (cyc != e.cyc);
        if (f[2] || f[3]) bad = bad || (mc_addr != e.addr) || (mc_din != e.data) || (mc_wdm != e.wdm);
        if (f[5]) bad = bad || (vid_rdata != e.data);
        if (f[6]) bad = bad || (cpu_rdata != e.data);
        if (bad) begin
          errors++;
          $display("FAIL event: got cyc=%0d flags=%b addr=%h din=%h wdm=%b vrd=%h crd=%h, required cyc=%0d flags=%b addr=%h data=%h wdm=%b",
                   cyc, f, mc_addr, mc_din, mc_wdm, vid_rdata, cpu_rdata, e.cyc, e.flags, e.addr, e.data, e.wdm);
        end
      end
    end
  end

  function automatic logic [79:0] all_outs();
    return {vid_ack, vid_rdata, vid_rvalid, cpu_ack, cpu_rdata, cpu_rvalid,
            mc_read, mc_write, mc_refresh, mc_addr, mc_din, mc_wdm, err};
  endfunction

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset(input logic hold_busy);
    resetn = 1'b0; init_busy = hold_busy;
    vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    vid_addr = '0; cpu_addr = '0; cpu_wdata = '0; cpu_wdm = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", all_outs(), '0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic vid_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int k;
    @(posedge clk); #1;
    model_rdata = d; vid_addr = a; vid_req = 1'b1; k = cyc;
    push(k + 1, F_VRD, a, '0, '0);
    push(k + 7, F_VRV, '0, d, '0);
    wait_cyc(k + 1); vid_req = 1'b0;
    wait_cyc(k + 10);
  endtask

  task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                        input logic [WDM_W-1:0] m, input logic [DATA_W-1:0] rd);
    int k;
    @(posedge clk); #1;
    model_rdata = rd; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_wdm = m; cpu_req = 1'b1; k = cyc;
    push(k + 1, we ? F_CWR : F_CRD, a, wd, m);
    if (!we) push(k + 7, F_CRV, '0, rd, '0);
    wait_cyc(k + 1); cpu_req = 1'b0;
    wait_cyc(k + 10);
  endtask

  initial begin
    int k;

    do_reset(1'b0);
    vid_read(22'h012345, 16'hBEEF);

    do_reset(1'b0);
    cpu_op(1'b1, 22'h3ABCD, 16'hA55A, 2'b01, 16'h0000);

    do_reset(1'b0);
    cpu_op(1'b0, 22'h000777, 16'h0000, 2'b00, 16'h1234);

    do_reset(1'b0);
    vid_read(22'h3FFFFF, 16'h0001);

    // Both clients held: 4 video grants then one CPU grant, twice over.
    do_reset(1'b0);
    @(posedge clk); #1;
    model_rdata = 16'hC0DE; vid_addr = 22'h000100; cpu_addr = 22'h000200; cpu_we = 1'b0;
    vid_req = 1'b1; cpu_req = 1'b1; k = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) begin
        push(k + 1 + 7 * i, F_CRD, 22'h000200, '0, '0);
        push(k + 7 + 7 * i, F_CRV, '0, 16'hC0DE, '0);
      end else begin
        push(k + 1 + 7 * i, F_VRD, 22'h000100, '0, '0);
        push(k + 7 + 7 * i, F_VRV, '0, 16'hC0DE, '0);
      end
    end
    wait_cyc(k + 64); vid_req = 1'b0; cpu_req = 1'b0;
    wait_cyc(k + 75);

    // Controller never answers: err at ISSUE+3, back to IDLE, err sticky.
    do_reset(1'b0);
    model_dead = 1'b1;
    @(posedge clk); #1;
    vid_addr = 22'h000042; vid_req = 1'b1; k = cyc;
    push(k + 1, F_VRD, 22'h000042, '0, '0);
    wait_cyc(k + 1); vid_req = 1'b0;
    wait_cyc(k + 3); chk("err_before_timeout", {79'd0, err}, 80'd0);
    wait_cyc(k + 4); chk("err_at_timeout", {79'd0, err}, 80'd1);
    cpu_we = 1'b1; cpu_addr = 22'h000099; cpu_wdata = 16'h0F0F; cpu_wdm = 2'b10; cpu_req = 1'b1;
    push(k + 5, F_CWR, 22'h000099, 16'h0F0F, 2'b10);
    wait_cyc(k + 5); cpu_req = 1'b0;
    wait_cyc(k + 14); chk("err_sticky", {79'd0, err}, 80'd1);
    model_dead = 1'b0;

    // Reset during WAIT_DONE: no rvalid; next request waits for controller init.
    do_reset(1'b0);
    @(posedge clk); #1;
    model_rdata = 16'h7777; vid_addr = 22'h2AAAA; vid_req = 1'b1; k = cyc;
    push(k + 1, F_VRD, 22'h2AAAA, '0, '0);
    wait_cyc(k + 1); vid_req = 1'b0;
    wait_cyc(k + 4);
    resetn = 1'b0; init_busy = 1'b1;
    #1 chk("reset_mid_outputs", all_outs(), '0);
    wait_cyc(k + 6);
    resetn = 1'b1; model_rdata = 16'h5555; vid_addr = 22'h000055; vid_req = 1'b1;
    wait_cyc(k + 9);
    init_busy = 1'b0;
    push(k + 10, F_VRD, 22'h000055, '0, '0);
    push(k + 16, F_VRV, '0, 16'h5555, '0);
    wait_cyc(k + 10); vid_req = 1'b0;
    wait_cyc(k + 20);

`ifdef SDRAM_ARB_REFRESH_EN
    // Two refreshes owed while the controller is busy: urgent refresh, video, then refresh.
    do_reset(1'b1);
    wait_cyc(cyc + 850);
    model_rdata = 16'h9999; vid_addr = 22'h001000; vid_req = 1'b1; init_busy = 1'b0; k = cyc;
    push(k + 1, F_REF, '0, '0, '0);
    push(k + 8, F_VRD, 22'h001000, '0, '0);
    push(k + 14, F_VRV, '0, 16'h9999, '0);
    push(k + 15, F_REF, '0, '0, '0);
    wait_cyc(k + 8); vid_req = 1'b0;
    wait_cyc(k + 25);
`endif

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending events, required 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
